app_add_error_monitor: RTL
==========================

# app_add_error_monitor

Streaming error monitor on the output side of the exact/approximate adder pair. It consumes one (exact sum, approximate sum) pair per handshake and computes the error distance ED = |exact − approximate|. Over a window of 2^WINDOW_LOG2 samples it accumulates the mismatch count, maximum ED and summed ED, then presents a report through a valid/ready handshake. It is used for on-chip quality characterisation of approximate adders, such as the 16-bit-approximation adder configuration.

## Interface
- WINDOW_LOG2, 8: log2 of samples per window; legal range 1..16.
- clk  input  1  clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- clear  input  1  synchronous; discards the partial window and any pending report.
- sample_valid  input  1  sample pair present.
- sample_ready  output  1  monitor accepts a sample this cycle (registered).
- of_output_ori  input  32  exact sum.
- of_output_app  input  32  approximate sum.
- report_valid  output  1  report fields valid.
- report_ready  input  1  consumer takes the report.
- report_mismatch_count  output  WINDOW_LOG2+1  samples with ED ≠ 0.
- report_max_ed  output  32  largest ED in the window.
- report_sum_ed  output  32+WINDOW_LOG2  sum of all EDs in the window.
- report_mean_ed  output  32  report_sum_ed >> WINDOW_LOG2 (truncating).
- window_count  output  16  completed windows (report handshakes); wraps 0xFFFF→0.

## Operation
- **Accept:** a sample is accepted when sample_valid && sample_ready.
- **ED:** computed from a 33-bit difference, ori − app. If negative, negate it; take the low 32 bits. Range 0..0xFFFFFFFF.
- **Stage 1 (register):** holds ED, a mismatch flag (ED ≠ 0) and a valid bit.
- **Stage 2 (accumulators):** when stage 1 is valid:
  - sum += ED;
  - max = max(max, ED);
  - count += mismatch.
  - None can overflow at the stated widths.
- **Sample counter:** WINDOW_LOG2+1 bits; counts accepted samples.
- **FSM states:** ACCUM, DRAIN, REPORT. Reset state is ACCUM.
  - ACCUM: sample_ready=1. When the 2^WINDOW_LOG2-th sample is accepted, go to DRAIN; sample_ready=0 from the next cycle.
  - DRAIN: sample_ready=0. The last sample moves from stage 1 into the accumulators. Go to REPORT next cycle.
  - REPORT: sample_ready=0, report_valid=1. Report fields are driven directly from the accumulators and are stable while waiting.
    - On report_ready: window_count += 1; accumulators, sample counter and stage 1 are zeroed; go to ACCUM.
    - report_ready while not in REPORT is ignored.
- **Ignored input:** sample_valid in DRAIN/REPORT is ignored; the data is not captured.
- **clear:**
  - Takes priority over all activity except reset.
  - Next cycle: ACCUM, accumulators, counter and stage 1 zeroed, sample_ready=1.
  - A pending report is dropped and window_count is unchanged.
  - A sample offered in the same cycle as clear is not accepted.
- **reset:** all registers to reset values regardless of state, including mid-window or in REPORT.

## Timing
- **Reset values:**
  - sample_ready=0 while reset is high; 1 the first cycle after.
  - report_valid=0.
  - All report fields 0; window_count=0.
- **Pipeline:** sample accepted at cycle T → registered in stage 1 at edge T+1 → accumulated at edge T+2.
- **Report latency:** final sample accepted at cycle T → DRAIN in cycle T+1 → report_valid high in cycle T+2.
- **Report release:** handshake in cycle R → report_valid=0 and sample_ready=1 in cycle R+1.
- **Throughput:** with sample_valid and report_ready held high, one window every 2^WINDOW_LOG2 + 2 cycles.
- **Outputs:** all registered; no combinational path from any input to any output.

## Test plan
All scenarios use WINDOW_LOG2=2 (4 samples per window).
- **Zero error:** four pairs with ori=app=0x1234 → report with count=0, max=0, sum=0, mean=0, two cycles after the fourth accept.
- **Both signs and extremes:** pairs (100,90), (90,100), (0,0xFFFFFFFF), (5,5) → count=3, max=0xFFFFFFFF, sum=0x100000013, mean=0x40000004.
- **Backpressure:** report_ready low for 10 cycles while sample_valid stays high with varying data → report_valid and fields held constant, sample_ready=0 throughout, no sample captured. Then report_ready=1 → window_count=1 and sample_ready=1 the next cycle.
- **Clear mid-window:** accept 2 samples with ED=7, pulse clear, then 4 samples with ED=1 → single report with count=4, sum=4, max=1, window_count=1.
- **Reset in REPORT:** assert reset while report_valid=1 → next cycle all outputs 0. Cycle after reset release: sample_ready=1.
- **Streaming:** sample_valid and report_ready tied high for 30 cycles → report_valid pulses every 6 cycles; window_count=5 at the end; every window's sum matches a reference model.

Source files
------------

// File: rtl/app_add_error_monitor.sv
// Windowed error-distance monitor for an exact/approximate adder pair.
// Reports mismatch count, max ED, summed ED and mean ED every 2^WINDOW_LOG2 samples.
module app_add_error_monitor #(
  parameter int WINDOW_LOG2 = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clear,
  input  logic                      sample_valid,
  output logic                      sample_ready,
  input  logic [31:0]               of_output_ori,
  input  logic [31:0]               of_output_app,
  output logic                      report_valid,
  input  logic                      report_ready,
  output logic [WINDOW_LOG2:0]      report_mismatch_count,
  output logic [31:0]               report_max_ed,
  output logic [32+WINDOW_LOG2-1:0] report_sum_ed,
  output logic [31:0]               report_mean_ed,
  output logic [15:0]               window_count
);

  localparam int SUM_W = 32 + WINDOW_LOG2;
  localparam logic [WINDOW_LOG2:0] LAST_IDX = {1'b0, {WINDOW_LOG2{1'b1}}};

  typedef enum logic [1:0] {
    ACCUM  = 2'd0,
    DRAIN  = 2'd1,
    REPORT = 2'd2
  } state_t;

  // Magnitude of the 33-bit difference; the low 32 bits of the negation equal
  // the negation of the low 32 bits, so only the sign bit is needed from bit 32.
  function automatic logic [31:0] calc_ed(input logic [31:0] ori, input logic [31:0] app);
    logic [32:0] diff;
    diff = {1'b0, ori} - {1'b0, app};
    if (diff[32]) begin
      return 32'd0 - diff[31:0];
    end else begin
      return diff[31:0];
    end
  endfunction

  state_t               state_r, state_nxt_s;
  logic                 sample_ready_r, report_valid_r;
  logic [WINDOW_LOG2:0] sample_cnt_r;
  logic                 s1_valid_r, s1_mis_r;
  logic [31:0]          s1_ed_r;
  logic [WINDOW_LOG2:0] mis_cnt_r;
  logic [31:0]          max_ed_r;
  logic [SUM_W-1:0]     sum_ed_r;
  logic [15:0]          window_cnt_r;
  logic                 accept_s, last_s, handshake_s;
  logic [31:0]          ed_s;

  assign accept_s    = sample_valid & sample_ready_r & ~clear;
  assign last_s      = accept_s & (sample_cnt_r == LAST_IDX);
  assign handshake_s = (state_r == REPORT) & report_ready & ~clear;
  assign ed_s        = calc_ed(of_output_ori, of_output_app);

  // Next-state logic; clear forces the window to restart.
  always_comb begin
    state_nxt_s = state_r;
    if (clear) begin
      state_nxt_s = ACCUM;
    end else begin
      case (state_r)
        ACCUM: begin
          if (last_s) begin
            state_nxt_s = DRAIN;
          end else begin
            state_nxt_s = ACCUM;
          end
        end
        DRAIN:  state_nxt_s = REPORT;
        REPORT: begin
          if (report_ready) begin
            state_nxt_s = ACCUM;
          end else begin
            state_nxt_s = REPORT;
          end
        end
        default: state_nxt_s = ACCUM;
      endcase
    end
  end

  // State register with registered handshake outputs decoded from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r        <= ACCUM;
      sample_ready_r <= 1'b0;
      report_valid_r <= 1'b0;
    end else begin
      state_r        <= state_nxt_s;
      sample_ready_r <= (state_nxt_s == ACCUM);
      report_valid_r <= (state_nxt_s == REPORT);
    end
  end

  // Stage 1 capture, sample counter and stage 2 accumulators.
  always_ff @(posedge clk) begin
    if (reset || clear || handshake_s) begin
      sample_cnt_r <= '0;
      s1_valid_r   <= 1'b0;
      s1_mis_r     <= 1'b0;
      s1_ed_r      <= 32'd0;
      mis_cnt_r    <= '0;
      max_ed_r     <= 32'd0;
      sum_ed_r     <= '0;
    end else begin
      if (accept_s) begin
        sample_cnt_r <= sample_cnt_r + {{WINDOW_LOG2{1'b0}}, 1'b1};
        s1_valid_r   <= 1'b1;
        s1_ed_r      <= ed_s;
        s1_mis_r     <= (ed_s != 32'd0);
      end else begin
        s1_valid_r   <= 1'b0;
      end
      if (s1_valid_r) begin
        sum_ed_r  <= sum_ed_r + {{WINDOW_LOG2{1'b0}}, s1_ed_r};
        mis_cnt_r <= mis_cnt_r + {{WINDOW_LOG2{1'b0}}, s1_mis_r};
        if (s1_ed_r > max_ed_r) begin
          max_ed_r <= s1_ed_r;
        end else begin
          max_ed_r <= max_ed_r;
        end
      end else begin
        sum_ed_r <= sum_ed_r;
      end
    end
  end

  // Completed-window counter; a report dropped by clear is not counted.
  always_ff @(posedge clk) begin
    if (reset) begin
      window_cnt_r <= 16'd0;
    end else if (handshake_s) begin
      window_cnt_r <= window_cnt_r + 16'd1;
    end else begin
      window_cnt_r <= window_cnt_r;
    end
  end

  assign sample_ready          = sample_ready_r;
  assign report_valid          = report_valid_r;
  assign report_mismatch_count = mis_cnt_r;
  assign report_max_ed         = max_ed_r;
  assign report_sum_ed         = sum_ed_r;
  assign report_mean_ed        = sum_ed_r[SUM_W-1:WINDOW_LOG2];
  assign window_count          = window_cnt_r;

endmodule
